// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG shift master.
// Op encodings, FSM states, TMS prefix patterns and segment helpers.
package jtag_pkg;

   localparam int unsigned CLK_DIV_DEF = 4;

   typedef enum logic [1:0] {
      OP_RESET = 2'd0,
      OP_IR    = 2'd1,
      OP_DR    = 2'd2,
      OP_RUN   = 2'd3
   } jtag_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RST   = 3'd1,
      ST_SEL   = 3'd2,
      ST_SHIFT = 3'd3,
      ST_EXIT  = 3'd4,
      ST_RUN   = 3'd5,
      ST_RSP   = 3'd6
   } jtag_state_e;

   // Bit i of each pattern is the TMS value of TCK bit i in that segment.
   localparam logic [7:0] TMS_RST     = 8'b0001_1111;
   localparam logic [5:0] TMS_RST_LEN = 6'd6;
   localparam logic [3:0] TMS_SEL_IR  = 4'b0011;
   localparam logic [3:0] TMS_SEL_DR  = 4'b0001;
   localparam logic [5:0] SEL_IR_LEN  = 6'd4;
   localparam logic [5:0] SEL_DR_LEN  = 6'd3;
   localparam logic [1:0] TMS_EXIT    = 2'b01;
   localparam logic [5:0] EXIT_LEN    = 6'd2;

   // First segment entered after a command is accepted.
   function automatic jtag_state_e first_state(input jtag_op_e op);
      jtag_state_e st;
      st = ST_RUN;
      case (op)
         OP_RESET: st = ST_RST;
         OP_IR:    st = ST_SEL;
         OP_DR:    st = ST_SEL;
         default:  st = ST_RUN;
      endcase
      return st;
   endfunction

   // Segment that follows a completed segment; RSP ends the op.
   function automatic jtag_state_e next_state(input jtag_state_e st);
      jtag_state_e nx;
      nx = ST_RSP;
      case (st)
         ST_SEL:   nx = ST_SHIFT;
         ST_SHIFT: nx = ST_EXIT;
         default:  nx = ST_RSP;
      endcase
      return nx;
   endfunction

   // Number of TCK bits in a segment.
   function automatic logic [5:0] seg_len(
      input jtag_state_e st,
      input logic        ir,
      input logic [5:0]  n
   );
      logic [5:0] len;
      len = n;
      case (st)
         ST_RST:  len = TMS_RST_LEN;
         ST_SEL:  len = ir ? SEL_IR_LEN : SEL_DR_LEN;
         ST_EXIT: len = EXIT_LEN;
         default: len = n;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider for the JTAG shift master.
// Emits one-cycle strobes marking the start of each TCK low and high phase.
module jtag_tck_gen
   import jtag_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic fall,
   output logic rise
);

   localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);
   localparam logic [8:0] HALF = 9'(CLK_DIV);

   logic [8:0] cnt_q;
   logic [8:0] cnt_d;

   // Count through one TCK period while enabled, park at zero otherwise.
   always_comb begin
      cnt_d = '0;
      if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 9'd1;
      end
   end

   // Divider register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fall = en && (cnt_q == '0);
   assign rise = en && (cnt_q == HALF);

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG shift master: runs TAP reset, IR/DR shifts and idle clocking.
// One command in, one response out, TCK derived from clk by CLK_DIV.
module jtag_shift_master
   import jtag_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        tck,
   output logic        tms,
   output logic        tdi,
   input  logic        tdo
);

   jtag_state_e state_q, state_d;
   jtag_op_e    op_q, op_d;
   logic [5:0]  n_q, n_d;
   logic [31:0] data_q, data_d;
   logic [5:0]  bit_q, bit_d;
   logic        tck_q, tck_d;
   logic        tms_q, tms_d;
   logic        tdi_q, tdi_d;
   logic [31:0] cap_q, cap_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        cmd_ready_q, cmd_ready_d;

   logic        tck_en;
   logic        tck_fall;
   logic        tck_rise;
   jtag_state_e seg_st;
   logic [5:0]  seg_bit;
   logic [4:0]  cap_idx;
   logic        is_ir;

   // TMS value for bit b of a segment.
   function automatic logic tms_of(
      input jtag_state_e st,
      input logic [5:0]  b,
      input logic        ir,
      input logic [5:0]  n
   );
      logic v;
      v = 1'b0;
      case (st)
         ST_RST:   v = TMS_RST[b[2:0]];
         ST_SEL:   v = ir ? TMS_SEL_IR[b[1:0]] : TMS_SEL_DR[b[1:0]];
         ST_SHIFT: v = (b == n - 6'd1);
         ST_EXIT:  v = TMS_EXIT[b[0]];
         default:  v = 1'b0;
      endcase
      return v;
   endfunction

   assign tck_en  = (state_q != ST_IDLE) && (state_q != ST_RSP);
   assign is_ir   = (op_q == OP_IR);
   assign cap_idx = 5'(bit_q - 6'd1);

   jtag_tck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tck_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (tck_en),
      .fall  (tck_fall),
      .rise  (tck_rise)
   );

   // Sequencer: accept, launch each TCK bit on its fall strobe, capture TDO on rise.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      n_d     = n_q;
      data_d  = data_q;
      bit_d   = bit_q;
      tck_d   = tck_q;
      tms_d   = tms_q;
      tdi_d   = tdi_q;
      cap_d   = cap_q;
      seg_st  = state_q;
      seg_bit = bit_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d    = jtag_op_e'(cmd_op);
               n_d     = {1'b0, cmd_len} + 6'd1;
               data_d  = cmd_data;
               cap_d   = '0;
               bit_d   = '0;
               state_d = first_state(jtag_op_e'(cmd_op));
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            if (tck_rise) begin
               tck_d = 1'b1;
               if (state_q == ST_SHIFT) begin
                  cap_d[cap_idx] = tdo;
               end
            end
            if (tck_fall) begin
               tck_d = 1'b0;
               if (bit_q == seg_len(state_q, is_ir, n_q)) begin
                  seg_st  = next_state(state_q);
                  seg_bit = '0;
               end
               if (seg_st == ST_RSP) begin
                  tdi_d   = 1'b0;
                  bit_d   = '0;
                  state_d = ST_RSP;
               end else begin
                  state_d = seg_st;
                  bit_d   = seg_bit + 6'd1;
                  tms_d   = tms_of(seg_st, seg_bit, is_ir, n_q);
                  tdi_d   = (seg_st == ST_SHIFT) ? data_q[seg_bit[4:0]] : 1'b0;
               end
            end
         end
      endcase
      rsp_valid_d = (state_d == ST_RSP);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // State and pin registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_RESET;
         n_q         <= '0;
         data_q      <= '0;
         bit_q       <= '0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         cap_q       <= '0;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         n_q         <= n_d;
         data_q      <= data_d;
         bit_q       <= bit_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         cap_q       <= cap_d;
         rsp_valid_q <= rsp_valid_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = cap_q;
   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Testbench for jtag_shift_master with a behavioural TAP on the pins.
// Table vectors, random commands, response hold and mid-shift reset.
module tb_jtag_shift_master;

   localparam int DIV = 2;
   localparam logic [31:0] IDCODE = 32'h1495_11C3;
   localparam logic [3:0]  IR_CAP = 4'b0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [4:0]  cmd_len = '0;
   logic [31:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        tck;
   logic        tms;
   logic        tdi;
   logic        tdo = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jtag_shift_master #(.CLK_DIV(DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .tck       (tck),
      .tms       (tms),
      .tdi       (tdi),
      .tdo       (tdo)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- behavioural TAP controller ----------------
   typedef enum int {
      T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PDR, T_EX2DR, T_UPDR,
      T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PIR, T_EX2IR, T_UPIR
   } tap_e;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      tap_e r;
      r = T_TLR;
      case (s)
         T_TLR:   r = m ? T_TLR   : T_RTI;
         T_RTI:   r = m ? T_SELDR : T_RTI;
         T_SELDR: r = m ? T_SELIR : T_CAPDR;
         T_CAPDR: r = m ? T_EX1DR : T_SHDR;
         T_SHDR:  r = m ? T_EX1DR : T_SHDR;
         T_EX1DR: r = m ? T_UPDR  : T_PDR;
         T_PDR:   r = m ? T_EX2DR : T_PDR;
         T_EX2DR: r = m ? T_UPDR  : T_SHDR;
         T_UPDR:  r = m ? T_SELDR : T_RTI;
         T_SELIR: r = m ? T_TLR   : T_CAPIR;
         T_CAPIR: r = m ? T_EX1IR : T_SHIR;
         T_SHIR:  r = m ? T_EX1IR : T_SHIR;
         T_EX1IR: r = m ? T_UPIR  : T_PIR;
         T_PIR:   r = m ? T_EX2IR : T_PIR;
         T_EX2IR: r = m ? T_UPIR  : T_SHIR;
         default: r = m ? T_SELDR : T_RTI;
      endcase
      return r;
   endfunction

   tap_e        tap = T_TLR;
   logic [31:0] dr = '0;
   logic [3:0]  ir = '0;
   bit          tms_log[$];
   bit          tdi_log[$];
   int          tck_pulses = 0;

   always @(posedge tck) begin
      tms_log.push_back(tms);
      tdi_log.push_back(tdi);
      tck_pulses++;
      case (tap)
         T_CAPDR: dr = IDCODE;
         T_SHDR:  dr = {tdi, dr[31:1]};
         T_CAPIR: ir = IR_CAP;
         T_SHIR:  ir = {tdi, ir[3:1]};
         default: ;
      endcase
      tap = tap_next(tap, tms);
   end

   always @(negedge tck) begin
      if (tap == T_SHDR) tdo = dr[0];
      else if (tap == T_SHIR) tdo = ir[0];
      else tdo = 1'b0;
   end

   // ---------------- reference expectations ----------------
   bit exp_tms[$];
   bit exp_tdi[$];

   task automatic build_exp(input int op, input int len, input logic [31:0] data);
      int n;
      n = len + 1;
      exp_tms.delete();
      exp_tdi.delete();
      if (op == 0) begin
         for (int i = 0; i < 5; i++) begin exp_tms.push_back(1); exp_tdi.push_back(0); end
         exp_tms.push_back(0); exp_tdi.push_back(0);
      end else if (op == 3) begin
         for (int i = 0; i < n; i++) begin exp_tms.push_back(0); exp_tdi.push_back(0); end
      end else begin
         exp_tms.push_back(1); exp_tdi.push_back(0);
         if (op == 1) begin exp_tms.push_back(1); exp_tdi.push_back(0); end
         exp_tms.push_back(0); exp_tdi.push_back(0);
         exp_tms.push_back(0); exp_tdi.push_back(0);
         for (int i = 0; i < n; i++) begin
            exp_tms.push_back(i == n - 1);
            exp_tdi.push_back(data[i]);
         end
         exp_tms.push_back(1); exp_tdi.push_back(0);
         exp_tms.push_back(0); exp_tdi.push_back(0);
      end
   endtask

   // A shift register of length L returns its capture value then the input delayed by L.
   function automatic logic [31:0] exp_rsp(input int op, input int len, input logic [31:0] data);
      logic [31:0] r;
      logic [31:0] id;
      logic [3:0]  cap;
      r = '0;
      id = IDCODE;
      cap = IR_CAP;
      for (int i = 0; i <= len; i++) begin
         if (op == 2) r[i] = id[i];
         else if (op == 1) r[i] = (i < 4) ? cap[i] : data[i-4];
      end
      return r;
   endfunction

   function automatic int seq_mism(input bit a[$], input bit b[$]);
      int m;
      m = (a.size() == b.size()) ? 0 : 1000;
      for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) m++;
      return m;
   endfunction

   // ---------------- drivers ----------------
   task automatic issue(input int op, input int len, input logic [31:0] data);
      int w;
      cmd_op = 2'(op);
      cmd_len = 5'(len);
      cmd_data = data;
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=0 required=1");
      end
      tms_log.delete();
      tdi_log.delete();
      tck_pulses = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input int op, input int len, input logic [31:0] data,
                          input int hold, input string tag,
                          output logic [31:0] rsp, output int pulses);
      int lat;
      int bad;
      logic [31:0] er;
      issue(op, len, data);
      lat = 0;
      for (int c = 1; c <= 400; c++) begin
         if (rsp_valid) break;
         @(posedge clk); #1;
         if (rsp_valid) lat = c;
      end
      build_exp(op, len, data);
      er = exp_rsp(op, len, data);
      chk($sformatf("%s_latency", tag), lat, exp_tms.size() * 2 * DIV + 1);
      chk($sformatf("%s_tck_at_rsp", tag), tck, 0);
      chk($sformatf("%s_pulses", tag), tck_pulses, exp_tms.size());
      chk($sformatf("%s_tms_seq", tag), seq_mism(tms_log, exp_tms), 0);
      chk($sformatf("%s_tdi_seq", tag), seq_mism(tdi_log, exp_tdi), 0);
      chk($sformatf("%s_rsp_data", tag), rsp_data, er);
      rsp = rsp_data;
      pulses = tck_pulses;
      if (hold > 0) begin
         bad = 0;
         for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== er || cmd_ready !== 1'b0 || tck !== 1'b0)
               bad++;
         end
         chk($sformatf("%s_hold_stable", tag), bad, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk($sformatf("%s_rsp_drop", tag), rsp_valid, 0);
      chk($sformatf("%s_ready_back", tag), cmd_ready, 1);
      chk($sformatf("%s_tap_rti", tag), tap, T_RTI);
   endtask

   typedef struct {
      int          op;
      int          len;
      logic [31:0] data;
      logic [31:0] rsp;
      int          tcks;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [31:0] r;
      int p;
      int bad;

      vecs[0] = '{0, 0,  32'h0,         32'h0,         6};
      vecs[1] = '{1, 3,  32'h2,         32'h1,         10};
      vecs[2] = '{2, 31, 32'h0,         32'h149511C3,  37};
      vecs[3] = '{3, 7,  32'hFFFF_FFFF, 32'h0,         8};
      vecs[4] = '{2, 0,  32'h1,         32'h1,         6};
      vecs[5] = '{1, 31, 32'hDEADBEEF,  32'hEADBEEF1,  38};
      vecs[6] = '{3, 31, 32'h0,         32'h0,         32};
      vecs[7] = '{2, 15, 32'h0000_FFFF, 32'h0000_11C3, 21};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tck", tck, 0);
      chk("rst_tms", tms, 1);
      chk("rst_tdi", tdi, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_release_ready", cmd_ready, 1);

      // table vectors
      for (int i = 0; i < 8; i++) begin
         run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, 0, $sformatf("vec%0d", i), r, p);
         chk($sformatf("vec%0d_tbl_rsp", i), r, vecs[i].rsp);
         chk($sformatf("vec%0d_tbl_tcks", i), p, vecs[i].tcks);
      end

      // response held while rsp_ready stays low
      run_cmd(2, 31, 32'h0, 10, "hold", r, p);

      // random commands
      for (int i = 0; i < 40; i++) begin
         run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), $urandom,
                 int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), r, p);
      end

      // reset during bit 10 of a DR shift
      issue(2, 31, 32'hA5A5_5A5A);
      for (int c = 0; c < 400; c++) begin
         if (tck_pulses >= 14) break;
         @(posedge clk); #1;
      end
      chk("mid_reached_bit10", tck_pulses, 14);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_tck", tck, 0);
      chk("mid_rst_tms", tms, 1);
      chk("mid_rst_tdi", tdi, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_rel_ready", cmd_ready, 1);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
      end
      chk("mid_no_stale_rsp", bad, 0);

      // TAP resync and one more shift after the abort
      run_cmd(0, 0, 32'h0, 0, "post_rst", r, p);
      run_cmd(2, 31, 32'h0, 0, "post_dr", r, p);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
